regfile_byte_loader: RTL and testbench

REGFILE_BYTE_LOADER -- requirements
Module: regfile_byte_loader

---
 rtl/regfile_byte_loader.sv | 193 +++++++++++++++++++
 tb/tb_regfile_byte_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_byte_loader.sv
// regfile_byte_loader: byte-stream command front end for a 32x32 register file.
// Write frame: cmd (bit7=1) then four data bytes LSB first -> one rf_we pulse.
// Read frame : cmd (bit7=0) -> register is latched and returned as four bytes,
//              LSB first, over a valid/ready output channel.
// Commands with reserved bits 6:5 set are dropped with a cmd_err pulse.
// A write frame that stalls for TIMEOUT_CYCLES is abandoned with cmd_err.
module regfile_byte_loader #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        cmd_err
);

  // Gap counter only needs to reach TIMEOUT_CYCLES-1; the timeout fires on
  // the idle cycle that would make it TIMEOUT_CYCLES.
  localparam int GW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_W0,
    S_W1,
    S_W2,
    S_W3,
    S_WRITE,
    S_RD_LATCH,
    S_TX0,
    S_TX1,
    S_TX2,
    S_TX3
  } state_t;

  state_t           r_state;
  logic             r_we;
  logic [4:0]       r_waddr;
  logic [31:0]      r_wdata;
  logic [4:0]       r_raddr;
  logic [31:0]      r_resp;
  logic [7:0]       r_odata;
  logic             r_ovalid;
  logic             r_err;
  logic [GW-1:0]    r_gap;

  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_rsvd;
  logic             w_wstate;
  logic [1:0]       w_widx;
  state_t           w_wnext;
  logic [7:0]       w_txnext;
  state_t           w_txstate;

  // Input is open only while collecting a frame (IDLE or a data-byte state).
  always_comb begin
    w_in_ready = 1'b0;
    w_wstate   = 1'b0;
    case (r_state)
      S_IDLE:                   w_in_ready = 1'b1;
      S_W0, S_W1, S_W2, S_W3: begin
        w_in_ready = 1'b1;
        w_wstate   = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_in_fire  = in_valid && w_in_ready;
  assign w_out_fire = r_ovalid && out_ready;
  assign w_rsvd     = |in_data[6:5];

  // Data-byte slot and successor for the write states.
  always_comb begin
    w_widx  = 2'd0;
    w_wnext = S_W1;
    case (r_state)
      S_W1:    begin w_widx = 2'd1; w_wnext = S_W2;    end
      S_W2:    begin w_widx = 2'd2; w_wnext = S_W3;    end
      S_W3:    begin w_widx = 2'd3; w_wnext = S_WRITE; end
      default: begin w_widx = 2'd0; w_wnext = S_W1;    end
    endcase
  end

  // Next response byte and successor for TX0..TX2 (TX3 exits to IDLE).
  always_comb begin
    w_txnext  = r_resp[15:8];
    w_txstate = S_TX1;
    case (r_state)
      S_TX1:   begin w_txnext = r_resp[23:16]; w_txstate = S_TX2; end
      S_TX2:   begin w_txnext = r_resp[31:24]; w_txstate = S_TX3; end
      default: begin w_txnext = r_resp[15:8];  w_txstate = S_TX1; end
    endcase
  end

  // Main FSM; every output is a register or a decode of r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_raddr  <= '0;
      r_resp   <= '0;
      r_odata  <= '0;
      r_ovalid <= 1'b0;
      r_err    <= 1'b0;
      r_gap    <= '0;
    end else begin
      r_we  <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_gap <= '0;
          if (w_in_fire) begin
            if (w_rsvd) begin
              r_err <= 1'b1;
            end else if (in_data[7]) begin
              r_waddr <= in_data[4:0];
              r_state <= S_W0;
            end else begin
              r_raddr <= in_data[4:0];
              r_state <= S_RD_LATCH;
            end
          end
        end
        S_W0, S_W1, S_W2, S_W3: begin
          if (w_in_fire) begin
            r_gap                  <= '0;
            r_wdata[8*w_widx +: 8] <= in_data;
            r_state                <= w_wnext;
            if (r_state == S_W3) r_we <= 1'b1;
          end else if (r_gap == GAP_LAST) begin
            r_gap   <= '0;
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        S_WRITE: begin
          r_state <= S_IDLE;
        end
        S_RD_LATCH: begin
          r_resp   <= rf_rdata;
          r_odata  <= rf_rdata[7:0];
          r_ovalid <= 1'b1;
          r_state  <= S_TX0;
        end
        S_TX0, S_TX1, S_TX2: begin
          if (w_out_fire) begin
            r_odata <= w_txnext;
            r_state <= w_txstate;
          end
        end
        S_TX3: begin
          if (w_out_fire) begin
            r_ovalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign busy      = (r_state != S_IDLE);
  assign rf_we     = r_we;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;
  assign rf_raddr  = r_raddr;
  assign out_data  = r_odata;
  assign out_valid = r_ovalid;
  assign cmd_err   = r_err;

  // w_wstate is kept as a readable decode of the write phase.
  logic w_unused;
  assign w_unused = w_wstate;

endmodule

// File: tb/tb_regfile_byte_loader.sv
// Directed bench for regfile_byte_loader: write/read frames, backpressure,
// reserved-bit rejection, frame timeout and asynchronous reset mid-frame.
module tb_regfile_byte_loader;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        cmd_err;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  int err_cnt = 0;

  logic [31:0] regs [32];
  logic [31:0] rd_force;
  logic        rd_force_en;

  regfile_byte_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Register file model
  assign rf_rdata = rd_force_en ? rd_force : regs[rf_raddr];
  always @(posedge clk) if (rf_we) regs[rf_waddr] <= rf_wdata;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (rf_we === 1'b1) we_cnt++;
    if (cmd_err === 1'b1) err_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready never rose for byte %h", b);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    rd_force_en = 1'b0; rd_force = '0;
    #12;
    tests++;
    if ({rf_we, rf_waddr, rf_wdata, rf_raddr, out_data, out_valid, busy, cmd_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got we=%b wa=%h wd=%h ra=%h od=%h ov=%b busy=%b err=%b want all 0",
               rf_we, rf_waddr, rf_wdata, rf_raddr, out_data, out_valid, busy, cmd_err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_release: in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
  endtask

  task automatic test_write;
    int w0 = we_cnt;
    send_byte(8'h83);
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || rf_we !== 1'b0) begin
      fails++; $display("FAIL write_w0: busy=%b in_ready=%b we=%b want 1/1/0", busy, in_ready, rf_we);
    end
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    tests++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h12345678 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL write_pulse: we=%b wa=%0d wd=%h rdy=%b want 1/3/12345678/0", rf_we, rf_waddr, rf_wdata, in_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (rf_we !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL write_done: we=%b busy=%b want 0/0", rf_we, busy);
    end
    repeat (3) @(posedge clk); #1;
    tests++;
    if (we_cnt - w0 != 1) begin
      fails++; $display("FAIL write_count: got %0d pulses want 1", we_cnt - w0);
    end
  endtask

  task automatic test_read;
    logic [7:0] exp [4];
    exp[0] = 8'hEF; exp[1] = 8'hBE; exp[2] = 8'hAD; exp[3] = 8'hDE;
    rd_force = 32'hDEADBEEF; rd_force_en = 1'b1; out_ready = 1'b1;
    send_byte(8'h03);
    tests++;
    if (rf_raddr !== 5'd3 || out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL read_latch: ra=%0d ov=%b rdy=%b busy=%b want 3/0/0/1", rf_raddr, out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        fails++; $display("FAIL read_byte%0d: ov=%b od=%h want 1/%h", i, out_valid, out_data, exp[i]);
      end
      @(posedge clk); #1;
    end
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL read_done: busy=%b ov=%b want 0/0", busy, out_valid);
    end
    rd_force_en = 1'b0;
  endtask

  task automatic test_backpressure;
    rd_force = 32'hDEADBEEF; rd_force_en = 1'b1; out_ready = 1'b0;
    send_byte(8'h03);
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'hEF) begin
      fails++; $display("FAIL bp_tx0: ov=%b od=%h want 1/ef", out_valid, out_data);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== 8'hBE || in_ready !== 1'b0) begin
        fails++; $display("FAIL bp_hold%0d: ov=%b od=%h rdy=%b want 1/be/0", i, out_valid, out_data, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_data !== 8'hAD) begin
      fails++; $display("FAIL bp_tx2: od=%h want ad", out_data);
    end
    @(posedge clk); #1;
    tests++;
    if (out_data !== 8'hDE) begin
      fails++; $display("FAIL bp_tx3: od=%h want de", out_data);
    end
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL bp_done: busy=%b want 0", busy);
    end
    rd_force_en = 1'b0;
  endtask

  task automatic test_bad_cmd;
    logic [7:0] cmds [3];
    int w0 = we_cnt;
    int e0 = err_cnt;
    cmds[0] = 8'hE1; cmds[1] = 8'hA2; cmds[2] = 8'h40;
    for (int i = 0; i < 3; i++) begin
      send_byte(cmds[i]);
      tests++;
      if (cmd_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
        fails++; $display("FAIL bad_cmd_%h: err=%b busy=%b rdy=%b want 1/0/1", cmds[i], cmd_err, busy, in_ready);
      end
      @(posedge clk); #1;
      tests++;
      if (cmd_err !== 1'b0) begin
        fails++; $display("FAIL bad_cmd_pulse_%h: err=%b want 0", cmds[i], cmd_err);
      end
    end
    tests++;
    if (err_cnt - e0 != 3 || we_cnt != w0) begin
      fails++; $display("FAIL bad_cmd_count: errs=%0d wes=%0d want 3/0", err_cnt - e0, we_cnt - w0);
    end
  endtask

  task automatic test_timeout;
    int w0 = we_cnt;
    int e0 = err_cnt;
    send_byte(8'h85); send_byte(8'h01); send_byte(8'h02);
    repeat (TO - 1) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1 || cmd_err !== 1'b0) begin
      fails++; $display("FAIL timeout_early: busy=%b err=%b want 1/0", busy, cmd_err);
    end
    @(posedge clk); #1;
    tests++;
    if (cmd_err !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL timeout_fire: err=%b busy=%b want 1/0", cmd_err, busy);
    end
    repeat (2) @(posedge clk); #1;
    tests++;
    if (we_cnt != w0 || err_cnt - e0 != 1) begin
      fails++; $display("FAIL timeout_count: wes=%0d errs=%0d want 0/1", we_cnt - w0, err_cnt - e0);
    end
    send_byte(8'h85); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    tests++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDDCCBBAA) begin
      fails++; $display("FAIL timeout_recover: we=%b wa=%0d wd=%h want 1/5/ddccbbaa", rf_we, rf_waddr, rf_wdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_addr0_wr_rd;
    logic [7:0] exp [4];
    exp[0] = 8'h44; exp[1] = 8'h33; exp[2] = 8'h22; exp[3] = 8'h11;
    send_byte(8'h80); send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    tests++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd0 || rf_wdata !== 32'h11223344) begin
      fails++; $display("FAIL addr0_write: we=%b wa=%0d wd=%h want 1/0/11223344", rf_we, rf_waddr, rf_wdata);
    end
    out_ready = 1'b1;
    send_byte(8'h00);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        fails++; $display("FAIL addr0_read%0d: ov=%b od=%h want 1/%h", i, out_valid, out_data, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midframe;
    int w0 = we_cnt;
    send_byte(8'h9F); send_byte(8'h11);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({rf_we, rf_waddr, rf_wdata, rf_raddr, out_data, out_valid, busy, cmd_err} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: we=%b wa=%h wd=%h ra=%h od=%h ov=%b busy=%b err=%b want all 0",
               rf_we, rf_waddr, rf_wdata, rf_raddr, out_data, out_valid, busy, cmd_err);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL midreset_ready: in_ready=%b want 1", in_ready);
    end
    repeat (4) @(posedge clk); #1;
    tests++;
    if (we_cnt != w0 || busy !== 1'b0) begin
      fails++; $display("FAIL midreset_nowrite: wes=%0d busy=%b want 0/0", we_cnt - w0, busy);
    end
    send_byte(8'h9F); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    tests++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'h04030201) begin
      fails++; $display("FAIL midreset_frame: we=%b wa=%0d wd=%h want 1/31/04030201", rf_we, rf_waddr, rf_wdata);
    end
    repeat (2) @(posedge clk); #1;
    tests++;
    if (we_cnt - w0 != 1) begin
      fails++; $display("FAIL midreset_count: got %0d pulses want 1", we_cnt - w0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_bad_cmd();
    test_timeout();
    test_addr0_wr_rd();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
